// File: rtl/onehot_rr_arbiter_if.sv
// Request/grant bundle between the request sources and the round-robin arbiter.
// The master side drives requests and release; the slave side is the arbiter.
interface onehot_rr_arbiter_if;
  logic [7:0] req;
  logic       owner_release;
  logic [7:0] grant;
  logic [2:0] grant_idx;
  logic       grant_vld;
  logic       timeout;

  modport master (
    output req,
    output owner_release,
    input  grant,
    input  grant_idx,
    input  grant_vld,
    input  timeout
  );

  modport slave (
    input  req,
    input  owner_release,
    output grant,
    output grant_idx,
    output grant_vld,
    output timeout
  );
endinterface

// File: rtl/onehot_rr_arbiter.sv
// Eight-way round-robin arbiter with a one-hot grant bus, a per-tenure hold
// limit and a programmable dead gap between tenures. Every output is registered.
// The owner's release line is called owner_release because "release" is a
// reserved word in SystemVerilog.
module onehot_rr_arbiter #(
  parameter int HOLD_MAX = 16,
  parameter int GAP_CYC  = 1
) (
  input  logic                 sys_clk,
  input  logic                 sys_rst_n,
  onehot_rr_arbiter_if.slave   bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    GAP   = 2'd2
  } state_t;

  localparam logic [7:0] HOLD_LAST = 8'(HOLD_MAX - 1);
  localparam logic [7:0] GAP_LAST  = (GAP_CYC > 0) ? 8'(GAP_CYC - 1) : 8'd0;
  localparam logic       HAS_GAP   = (GAP_CYC > 0) ? 1'b1 : 1'b0;

  // First set request bit searching p, p+1, ..., 7, 0, ..., p-1.
  // Walking the offsets downwards lets the smallest offset win last.
  function automatic logic [2:0] rr_pick(input logic [7:0] r, input logic [2:0] p);
    logic [2:0] w;
    logic [2:0] c;
    w = 3'd0;
    for (int k = 7; k >= 0; k--) begin
      c = p + 3'(k);
      if (r[c]) begin
        w = c;
      end else begin
        w = w;
      end
    end
    return w;
  endfunction

  // Same one-hot code as the 3-to-8 decoder elsewhere in the datapath.
  function automatic logic [7:0] onehot8(input logic [2:0] idx);
    return 8'b0000_0001 << idx;
  endfunction

  state_t     state_r, state_nxt_s;
  logic [2:0] ptr_r, ptr_nxt_s;
  logic [7:0] hold_cnt_r, hold_nxt_s;
  logic [7:0] gap_cnt_r, gap_nxt_s;
  logic [2:0] grant_idx_r, idx_nxt_s;
  logic       grant_vld_r, vld_nxt_s;
  logic [7:0] grant_r, grant_nxt_s;
  logic       timeout_r, tmo_nxt_s;

  logic       any_req_s;
  logic       owner_req_s;
  logic       expiry_s;
  logic       tenure_end_s;
  logic       expiry_only_s;
  logic [2:0] winner_s;

  assign any_req_s     = |bus.req;
  assign owner_req_s   = bus.req[grant_idx_r];
  assign expiry_s      = (hold_cnt_r == HOLD_LAST);
  assign tenure_end_s  = (state_r == GRANT) &&
                         (bus.owner_release || !owner_req_s || expiry_s);
  // A timeout is only reported when nothing else would have ended the tenure.
  assign expiry_only_s = (state_r == GRANT) && expiry_s &&
                         !bus.owner_release && owner_req_s;
  assign winner_s      = rr_pick(bus.req, ptr_r);

  // State register.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state selection: arbitrate, hold the tenure, then sit out the gap.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (any_req_s) begin
          state_nxt_s = GRANT;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      GRANT: begin
        if (tenure_end_s) begin
          if (HAS_GAP) begin
            state_nxt_s = GAP;
          end else begin
            state_nxt_s = IDLE;
          end
        end else begin
          state_nxt_s = GRANT;
        end
      end
      GAP: begin
        if (gap_cnt_r == GAP_LAST) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = GAP;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // Next values of the registered outputs, pointer and counters.
  always_comb begin
    idx_nxt_s  = grant_idx_r;
    vld_nxt_s  = grant_vld_r;
    tmo_nxt_s  = 1'b0;
    ptr_nxt_s  = ptr_r;
    hold_nxt_s = hold_cnt_r;
    gap_nxt_s  = gap_cnt_r;
    case (state_r)
      IDLE: begin
        if (any_req_s) begin
          idx_nxt_s  = winner_s;
          vld_nxt_s  = 1'b1;
          hold_nxt_s = 8'd0;
        end else begin
          idx_nxt_s  = 3'd0;
          vld_nxt_s  = 1'b0;
        end
      end
      GRANT: begin
        if (tenure_end_s) begin
          idx_nxt_s  = 3'd0;
          vld_nxt_s  = 1'b0;
          tmo_nxt_s  = expiry_only_s;
          ptr_nxt_s  = grant_idx_r + 3'd1;
          hold_nxt_s = 8'd0;
          gap_nxt_s  = 8'd0;
        end else if (expiry_s) begin
          hold_nxt_s = hold_cnt_r;
        end else begin
          hold_nxt_s = hold_cnt_r + 8'd1;
        end
      end
      GAP: begin
        if (gap_cnt_r == GAP_LAST) begin
          gap_nxt_s = 8'd0;
        end else begin
          gap_nxt_s = gap_cnt_r + 8'd1;
        end
      end
      default: begin
        idx_nxt_s  = 3'd0;
        vld_nxt_s  = 1'b0;
        ptr_nxt_s  = 3'd0;
        hold_nxt_s = 8'd0;
        gap_nxt_s  = 8'd0;
      end
    endcase
    if (vld_nxt_s) begin
      grant_nxt_s = onehot8(idx_nxt_s);
    end else begin
      grant_nxt_s = 8'h00;
    end
  end

  // Output, pointer and counter registers.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      grant_idx_r <= 3'd0;
      grant_vld_r <= 1'b0;
      grant_r     <= 8'h00;
      timeout_r   <= 1'b0;
      ptr_r       <= 3'd0;
      hold_cnt_r  <= 8'd0;
      gap_cnt_r   <= 8'd0;
    end else begin
      grant_idx_r <= idx_nxt_s;
      grant_vld_r <= vld_nxt_s;
      grant_r     <= grant_nxt_s;
      timeout_r   <= tmo_nxt_s;
      ptr_r       <= ptr_nxt_s;
      hold_cnt_r  <= hold_nxt_s;
      gap_cnt_r   <= gap_nxt_s;
    end
  end

  assign bus.grant     = grant_r;
  assign bus.grant_idx = grant_idx_r;
  assign bus.grant_vld = grant_vld_r;
  assign bus.timeout   = timeout_r;

endmodule

// File: tb/tb_onehot_rr_arbiter.sv
// Bench for onehot_rr_arbiter: two instances (HOLD 4/GAP 1 and HOLD 2/GAP 0)
// share one stimulus; a tenure-level model is compared every cycle and
// directed literal expectations pin the scenarios.
module tb_onehot_rr_arbiter;

  localparam int HOLD_A = 4;
  localparam int GAP_A  = 1;
  localparam int HOLD_B = 2;
  localparam int GAP_B  = 0;

  logic       sys_clk   = 1'b0;
  logic       sys_rst_n = 1'b0;
  logic [7:0] req       = 8'h00;
  logic       rel       = 1'b0;

  int checks = 0;
  int errors = 0;

  onehot_rr_arbiter_if ifa ();
  onehot_rr_arbiter_if ifb ();

  assign ifa.req           = req;
  assign ifa.owner_release = rel;
  assign ifb.req           = req;
  assign ifb.owner_release = rel;

  onehot_rr_arbiter #(.HOLD_MAX(HOLD_A), .GAP_CYC(GAP_A)) dut_a (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .bus       (ifa)
  );

  onehot_rr_arbiter #(.HOLD_MAX(HOLD_B), .GAP_CYC(GAP_B)) dut_b (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .bus       (ifb)
  );

  // Clock.
  always #5 sys_clk = ~sys_clk;

  // ---------------- tenure-level model ----------------
  // owner: -1 when nobody holds the resource; held: grant cycles completed;
  // dead: zero cycles still to wait before arbitration; prio: search start.
  int m_owner [2] = '{-1, -1};
  int m_held  [2] = '{0, 0};
  int m_dead  [2] = '{0, 0};
  int m_prio  [2] = '{0, 0};
  bit m_tmo   [2] = '{1'b0, 1'b0};
  int n_owner [2];
  int n_held  [2];
  int n_dead  [2];
  int n_prio  [2];
  bit n_tmo   [2];

  function automatic void model_next(
    input int hold, input int gap,
    input int owner, input int held, input int dead, input int prio,
    input logic [7:0] r, input logic rl,
    output int o, output int h, output int d, output int p, output bit t);
    o = owner; h = held; d = dead; p = prio; t = 1'b0;
    if (owner >= 0) begin
      h = held + 1;
      if (rl || !r[owner] || h == hold) begin
        t = (h == hold) && !rl && r[owner];
        p = (owner + 1) % 8;
        o = -1;
        d = gap;
        h = 0;
      end
    end else if (dead > 0) begin
      d = dead - 1;
    end else if (r != 8'h00) begin
      for (int k = 0; k < 8; k++) begin
        if (o < 0 && r[(prio + k) % 8]) o = (prio + k) % 8;
      end
      h = 0;
    end
  endfunction

  // Model next state for both instances.
  always_comb begin
    model_next(HOLD_A, GAP_A, m_owner[0], m_held[0], m_dead[0], m_prio[0], req, rel,
               n_owner[0], n_held[0], n_dead[0], n_prio[0], n_tmo[0]);
    model_next(HOLD_B, GAP_B, m_owner[1], m_held[1], m_dead[1], m_prio[1], req, rel,
               n_owner[1], n_held[1], n_dead[1], n_prio[1], n_tmo[1]);
  end

  // Model state update with asynchronous reset.
  always @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      for (int i = 0; i < 2; i++) begin
        m_owner[i] <= -1; m_held[i] <= 0; m_dead[i] <= 0;
        m_prio[i]  <= 0;  m_tmo[i]  <= 1'b0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        m_owner[i] <= n_owner[i]; m_held[i] <= n_held[i]; m_dead[i] <= n_dead[i];
        m_prio[i]  <= n_prio[i];  m_tmo[i]  <= n_tmo[i];
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] exp_word(input int i);
    logic [7:0] g;
    logic [2:0] idx;
    logic       v;
    if (m_owner[i] >= 0) begin
      g = 8'h01 << m_owner[i];
      idx = 3'(m_owner[i]);
      v = 1'b1;
    end else begin
      g = 8'h00;
      idx = 3'd0;
      v = 1'b0;
    end
    return {8'h00, g, 5'd0, idx, 3'd0, v, 3'd0, m_tmo[i]};
  endfunction

  // Every-cycle comparison of both instances against the model.
  always @(negedge sys_clk) begin
    chk("model_a", {8'h00, ifa.grant, 5'd0, ifa.grant_idx, 3'd0, ifa.grant_vld, 3'd0, ifa.timeout},
        exp_word(0));
    chk("model_b", {8'h00, ifb.grant, 5'd0, ifb.grant_idx, 3'd0, ifb.grant_vld, 3'd0, ifb.timeout},
        exp_word(1));
    chk("onehot_a", 32'($countones(ifa.grant) <= 1), 32'd1);
    chk("onehot_b", 32'($countones(ifb.grant) <= 1), 32'd1);
  end

  // ---------------- directed stimulus ----------------
  task automatic tick();
    @(posedge sys_clk);
    #2;
  endtask

  task automatic do_reset();
    sys_rst_n = 1'b0;
    req = 8'h00;
    rel = 1'b0;
    tick();
    tick();
    sys_rst_n = 1'b1;
  endtask

  logic [7:0] rot_seq [9];

  // Directed scenarios with hand-computed expectations.
  initial begin
    rot_seq = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h01};

    do_reset();
    chk("reset_grant_a", {24'd0, ifa.grant}, 32'h00);
    chk("reset_vld_a", {31'd0, ifa.grant_vld}, 32'd0);
    chk("reset_tmo_a", {31'd0, ifa.timeout}, 32'd0);

    // Single request, HOLD 4 / GAP 1.
    req = 8'h08;
    for (int c = 0; c < 4; c++) begin
      tick();
      chk("single_grant", {24'd0, ifa.grant}, 32'h08);
      chk("single_idx", {29'd0, ifa.grant_idx}, 32'd3);
    end
    tick();
    chk("single_expire_grant", {24'd0, ifa.grant}, 32'h00);
    chk("single_timeout", {31'd0, ifa.timeout}, 32'd1);
    tick();
    chk("single_gap_grant", {24'd0, ifa.grant}, 32'h00);
    chk("single_gap_timeout", {31'd0, ifa.timeout}, 32'd0);
    tick();
    chk("single_regrant", {24'd0, ifa.grant}, 32'h08);

    // Full contention rotation on instance B, HOLD 2 / GAP 0.
    do_reset();
    req = 8'hFF;
    for (int i = 0; i < 9; i++) begin
      tick();
      chk("rot_grant1", {24'd0, ifb.grant}, {24'd0, rot_seq[i]});
      tick();
      chk("rot_grant2", {24'd0, ifb.grant}, {24'd0, rot_seq[i]});
      tick();
      chk("rot_zero", {24'd0, ifb.grant}, 32'h00);
      chk("rot_timeout", {31'd0, ifb.timeout}, 32'd1);
    end

    // Early release with pointer wrap.
    do_reset();
    req = 8'h40;
    tick();
    chk("wrap_owner6", {24'd0, ifa.grant}, 32'h40);
    req = 8'h41;
    rel = 1'b1;
    tick();
    rel = 1'b0;
    chk("wrap_drop", {24'd0, ifa.grant}, 32'h00);
    chk("wrap_no_timeout", {31'd0, ifa.timeout}, 32'd0);
    tick();
    chk("wrap_gap", {24'd0, ifa.grant}, 32'h00);
    tick();
    chk("wrap_next", {24'd0, ifa.grant}, 32'h01);
    chk("wrap_next_idx", {29'd0, ifa.grant_idx}, 32'd0);

    // Request drop hands over to requester 5.
    do_reset();
    req = 8'h04;
    tick();
    chk("drop_owner2", {24'd0, ifa.grant}, 32'h04);
    req = 8'h24;
    tick();
    chk("drop_still2", {24'd0, ifa.grant}, 32'h04);
    req = 8'h20;
    tick();
    chk("drop_zero", {24'd0, ifa.grant}, 32'h00);
    chk("drop_no_timeout", {31'd0, ifa.timeout}, 32'd0);
    tick();
    chk("drop_gap", {24'd0, ifa.grant}, 32'h00);
    tick();
    chk("drop_next", {24'd0, ifa.grant}, 32'h20);
    chk("drop_next_idx", {29'd0, ifa.grant_idx}, 32'd5);

    // Release coinciding with expiry on the last grant cycle.
    do_reset();
    req = 8'h08;
    tick();
    chk("coin_grant", {24'd0, ifa.grant}, 32'h08);
    tick();
    tick();
    tick();
    chk("coin_last_cycle", {24'd0, ifa.grant}, 32'h08);
    req = 8'h18;
    rel = 1'b1;
    tick();
    rel = 1'b0;
    chk("coin_drop", {24'd0, ifa.grant}, 32'h00);
    chk("coin_no_timeout", {31'd0, ifa.timeout}, 32'd0);
    tick();
    tick();
    chk("coin_ptr_advance", {24'd0, ifa.grant}, 32'h10);

    // Asynchronous reset during GRANT and during GAP.
    do_reset();
    req = 8'h10;
    tick();
    chk("rst_owner4", {24'd0, ifa.grant}, 32'h10);
    tick();
    sys_rst_n = 1'b0;
    #1;
    chk("rst_grant_mid", {24'd0, ifa.grant, 5'd0, ifa.grant_idx, 3'd0, ifa.grant_vld, 3'd0, ifa.timeout}, 32'd0);
    tick();
    tick();
    sys_rst_n = 1'b1;
    tick();
    chk("rst_regrant", {24'd0, ifa.grant}, 32'h10);
    rel = 1'b1;
    tick();
    rel = 1'b0;
    chk("rst_in_gap", {24'd0, ifa.grant}, 32'h00);
    sys_rst_n = 1'b0;
    #1;
    chk("rst_gap_mid", {24'd0, ifa.grant, 5'd0, ifa.grant_idx, 3'd0, ifa.grant_vld, 3'd0, ifa.timeout}, 32'd0);
    req = 8'hFF;
    tick();
    tick();
    sys_rst_n = 1'b1;
    tick();
    chk("rst_prio0_a", {24'd0, ifa.grant}, 32'h01);
    chk("rst_prio0_b", {24'd0, ifb.grant}, 32'h01);
    req = 8'h00;
    tick();
    tick();
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
